rr_pop_scheduler: RTL
=====================

Name: rr_pop_scheduler

Overview:
- Round-robin pop initiator for a bank of 4 input FIFOs feeding the roundrobin mid stage.
- Drives one-hot pop strobes into the FIFOs, and pop_id/valid into the mid stage, from the FIFO empty flags and a per-queue quantum.
- Each queue is served for up to its quantum of consecutive pops before the grant rotates.
- Honors a downstream pause (almost-full) flag.

Parameters:
- NQ, 4, number of queues (pop_id width fixed at 2; only NQ=4 supported).
- QW, 5, quantum field width per queue.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- empty  input  4  FIFO empty flags, bit i = queue i.
- request  input  20  quantum config: queue i quantum = request[5i+4:5i]; 0 = queue disabled.
- pause  input  1  downstream almost-full; 1 blocks all pops.
- pop  output  4  one-hot pop strobe to FIFOs (combinational from registered state).
- pop_id  output  2  queue index of the data presented this cycle (registered).
- valid  output  1  FIFO read data valid this cycle (registered).
- credit  output  5  remaining pops in current quantum (debug/verification).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset=0 resets immediately, independent of clk).
- Reset values:
  - State=IDLE, ptr=0, credit=0.
  - pop=0000, pop_id=00, valid=0.
- Eligibility: eligible(i) = !empty[i] && quantum(i)!=0.
- Next-queue search: scan ptr+1, ptr+2, ptr+3, ptr+4 (wrapping modulo 4); select the first eligible queue. ptr itself is checked last.
- IDLE state:
  - pop=0.
  - If !pause and any queue is eligible: load ptr=found queue, credit=quantum(found), go to SERVE.
  - From reset, the search starts at ptr=0, so queue 1 has first priority and queue 0 is checked last.
- SERVE state, pop condition: pop[ptr]=1 iff !pause && !empty[ptr] && credit!=0.
- SERVE state, on a pop edge:
  - credit decrements.
  - If credit was 1 (quantum exhausted): search for the next queue. If found, load ptr and credit=quantum(new). If none, go to IDLE.
  - If credit was 1 and ptr is the only eligible queue, it is reselected with a fresh credit. There is no bubble.
- SERVE state, empty[ptr]=1 with !pause:
  - No pop this cycle.
  - Search for the next queue and switch at the edge (one bubble cycle); go to IDLE if none is found.
  - Any unused credit is discarded.
- pause=1 in any state:
  - pop=0.
  - ptr, credit and state are all held.
  - valid still reflects the previous cycle's pop.
- valid / pop_id: registered copy of (|pop) and ptr, so both assert the cycle after the pop strobe (matches 1-cycle FIFO read latency). Exactly one valid pulse per pop.
- At most one pop bit is high in any cycle.
- A quantum change while in SERVE takes effect only at the next credit load.
- Reset asserted mid-quantum: immediate return to reset values. Any in-flight valid is dropped, and no pop occurs until reset deasserts and an edge passes.
- Credit arithmetic: 5-bit unsigned, never decrements below 0. Maximum quantum is 31.

Test Plan:
- Reset then all empty=1111, request=20'b11001110000110111001: stays IDLE, pop=0, valid=0 for 20 cycles.
- request quanta q0..q3=2,3,1,2, empty=0000 held: pop sequence is q1 x3, q2 x1, q3 x2, q0 x2, repeating. Each valid pulse trails its pop by 1 cycle with the matching pop_id; no idle cycles.
- Serving q1 (credit=3): raise empty[1] after the first pop. Required: one bubble cycle with pop=0, then pop[2]=1; credit reloads to quantum(q2).
- Quantum of q2 set to 0 with all queues non-empty: q2 is never popped; the rotation is q1, q3, q0.
- pause=1 for 5 cycles mid-quantum (credit=2): pop=0 throughout and credit held at 2. On release, 2 more pops from the same queue, then rotation continues.
- Assert reset (low) mid-SERVE, between clock edges: pop, valid and credit go to 0 immediately. After release with q3 only non-empty: the first pop is pop[3] two edges later, and pop_id=3 accompanies valid.

Source files
------------

// File: rtl/rr_pop_scheduler.sv
// Round-robin pop initiator for a bank of input FIFOs: serves each queue for up
// to its quantum of back-to-back pops, then rotates to the next eligible queue.
module rr_pop_scheduler #(
    parameter int NQ = 4,
    parameter int QW = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NQ-1:0]    empty,
    input  logic [NQ*QW-1:0] request,
    input  logic             pause,
    output logic [NQ-1:0]    pop,
    output logic [1:0]       pop_id,
    output logic             valid,
    output logic [QW-1:0]    credit
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    logic [0:0]    state_reg, state_next;
    logic [1:0]    ptr_reg, ptr_next;
    logic [QW-1:0] credit_reg, credit_next;
    logic          valid_reg;
    logic [1:0]    pop_id_reg;

    logic [QW-1:0] quantum [NQ];
    logic [NQ-1:0] eligible;
    logic          found;
    logic [1:0]    found_idx;
    logic          pop_fire;

    generate
        for (genvar gi = 0; gi < NQ; gi++) begin : g_queue
            assign quantum[gi]  = request[gi*QW +: QW];
            assign eligible[gi] = !empty[gi] && (quantum[gi] != '0);
        end
    endgenerate

    // Scan from the farthest offset down so the nearest queue after ptr wins;
    // offset NQ wraps to ptr itself, which therefore has the lowest priority.
    always_comb begin
        found     = 1'b0;
        found_idx = ptr_reg;
        for (int k = NQ; k >= 1; k--) begin
            if (eligible[ptr_reg + 2'(k)]) begin
                found     = 1'b1;
                found_idx = ptr_reg + 2'(k);
            end
        end
    end

    assign pop_fire = (state_reg == ST_SERVE) && !pause && !empty[ptr_reg]
                      && (credit_reg != '0);
    assign pop      = pop_fire ? ({{(NQ-1){1'b0}}, 1'b1} << ptr_reg) : '0;

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        credit_next = credit_reg;
        if (!pause) begin
            if (state_reg == ST_IDLE) begin
                if (found) begin
                    state_next  = ST_SERVE;
                    ptr_next    = found_idx;
                    credit_next = quantum[found_idx];
                end
            end else if (pop_fire && (credit_reg != QW'(1))) begin
                credit_next = credit_reg - QW'(1);
            end else begin
                // Quantum exhausted or current queue ran dry: leftover credit is dropped.
                if (found) begin
                    ptr_next    = found_idx;
                    credit_next = quantum[found_idx];
                end else begin
                    state_next  = ST_IDLE;
                    credit_next = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= '0;
            credit_reg <= '0;
            valid_reg  <= 1'b0;
            pop_id_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            credit_reg <= credit_next;
            valid_reg  <= |pop;
            pop_id_reg <= ptr_reg;
        end
    end

    assign valid  = valid_reg;
    assign pop_id = pop_id_reg;
    assign credit = credit_reg;

endmodule
